// File: rtl/calc_pkg.sv
// Shared definitions for the calculator driver: op codes, packed-bus bit positions,
// driver FSM states and the shadow-accumulator arithmetic.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_SHL = 2'b11
  } calc_op_t;

  localparam int unsigned CALC_CLK      = 0;
  localparam int unsigned CALC_RST      = 1;
  localparam int unsigned CALC_EN       = 2;
  localparam int unsigned CALC_OPND_LSB = 3;
  localparam int unsigned CALC_OPND_MSB = 5;
  localparam int unsigned CALC_OP_LSB   = 6;
  localparam int unsigned CALC_OP_MSB   = 7;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_CAPTURE,
    ST_RESP
  } calc_state_t;

  // 8-bit modulo arithmetic matching the calculator; SHL drops bits past bit 7.
  function automatic logic [7:0] calc_apply(input calc_op_t op, input logic [7:0] acc,
                                            input logic [2:0] opnd);
    logic [7:0] res;
    res = acc;
    case (op)
      OP_ADD:  res = acc + {5'b0, opnd};
      OP_SUB:  res = acc - {5'b0, opnd};
      OP_XOR:  res = acc ^ {5'b0, opnd};
      OP_SHL:  res = acc << opnd;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_clock_gen.sv
// Calculator clock generator: low phase then high phase of HALF_PERIOD system cycles each,
// with start/end-of-cycle strobes; held low and rewound while run is low.
module calc_clock_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic calc_clk,
  output logic cyc_start,
  output logic cyc_end
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!run) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    calc_clk  = run & phase_q;
    cyc_start = run & ~phase_q & (cnt_q == '0);
    cyc_end   = run & phase_q & (cnt_q == LAST);
  end

endmodule

// File: rtl/calc_driver.sv
// Host-side driver for the packed-byte calculator: sequences INIT/ARM/FIRE calc cycles,
// captures the result and checks it against a shadow accumulator.
module calc_driver
  import calc_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_operand,
  output logic [7:0] calc_in,
  input  logic [7:0] calc_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_mismatch
);

  calc_state_t state_q, state_d;

  logic       run;
  logic       calc_clk;
  logic       cyc_start;
  logic       cyc_end;
  logic       accept;

  logic       clr_q;
  calc_op_t   op_q;
  logic [2:0] opnd_q;
  logic [7:0] shadow_q;
  logic [7:0] shadow_nxt;
  logic [7:0] rsp_data_q;
  logic       rsp_mism_q;

  calc_clock_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .calc_clk  (calc_clk),
    .cyc_start (cyc_start),
    .cyc_end   (cyc_end)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_INIT: begin
        run = 1'b1;
        if (cyc_end) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_d = ST_ARM;
      end
      ST_ARM: begin
        run = 1'b1;
        if (cyc_end) state_d = clr_q ? ST_CAPTURE : ST_FIRE;
      end
      ST_FIRE: begin
        run = 1'b1;
        if (cyc_end) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    shadow_nxt = clr_q ? '0 : calc_apply(op_q, shadow_q, opnd_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_q      <= 1'b0;
      op_q       <= OP_ADD;
      opnd_q     <= '0;
      shadow_q   <= '0;
      rsp_data_q <= '0;
      rsp_mism_q <= 1'b0;
    end else begin
      if (accept) begin
        clr_q  <= cmd_clear;
        op_q   <= calc_op_t'(cmd_op);
        opnd_q <= cmd_operand;
      end
      if (state_q == ST_INIT && cyc_start) begin
        shadow_q <= '0;
      end
      if (state_q == ST_CAPTURE) begin
        shadow_q   <= shadow_nxt;
        rsp_data_q <= calc_out;
        rsp_mism_q <= (calc_out != shadow_nxt);
      end
    end
  end

  // Field bits are decoded from state and latches, which only move on calc-cycle boundaries.
  always_comb begin
    calc_in = '0;
    calc_in[CALC_CLK] = calc_clk;
    calc_in[CALC_RST] = (state_q == ST_INIT) || (state_q == ST_ARM && clr_q);
    calc_in[CALC_EN]  = (state_q == ST_FIRE);
    calc_in[CALC_OPND_MSB:CALC_OPND_LSB] = opnd_q;
    calc_in[CALC_OP_MSB:CALC_OP_LSB]     = op_q;
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_mismatch = rsp_mism_q;

endmodule

// File: tb/tb_calc_driver.sv
// Bench for calc_driver: behavioural calculator on the packed bus, table vectors,
// hand-written corner sequences and randomized commands against an arithmetic model.
module tb_calc_driver;

  localparam int HP     = 2;
  localparam int OP_LAT = 4 * HP + 1;
  localparam int CL_LAT = 2 * HP + 1;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [1:0] cmd_op;
  logic [2:0] cmd_operand;
  logic [7:0] calc_in;
  logic [7:0] calc_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_mismatch;

  int checks   = 0;
  int failures = 0;

  calc_driver #(
    .HALF_PERIOD(HP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_clear    (cmd_clear),
    .cmd_op       (cmd_op),
    .cmd_operand  (cmd_operand),
    .calc_in      (calc_in),
    .calc_out     (calc_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_mismatch (rsp_mismatch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Calculator model: acts on its clock's rising edge, executes on a rising enable.
  logic [7:0] calc_acc = 8'h00;
  logic       en_prev  = 1'b0;
  logic       fault_zero = 1'b0;
  int         clk_rises = 0;
  int         rst_rises = 0;

  always @(posedge calc_in[0]) begin
    clk_rises++;
    if (calc_in[1]) begin
      rst_rises++;
      calc_acc = 8'h00;
      en_prev  = 1'b0;
    end else begin
      if (calc_in[2] && !en_prev) begin
        case (calc_in[7:6])
          2'b00: calc_acc = calc_acc + {5'b0, calc_in[5:3]};
          2'b01: calc_acc = calc_acc - {5'b0, calc_in[5:3]};
          2'b10: calc_acc = calc_acc ^ {5'b0, calc_in[5:3]};
          default: calc_acc = calc_acc << calc_in[5:3];
        endcase
      end
      en_prev = calc_in[2];
    end
  end

  assign calc_out = fault_zero ? 8'h00 : calc_acc;

  // Reference model in plain integer arithmetic.
  int ref_acc = 0;

  function automatic int ref_step(input int acc, input bit clr, input int op, input int opnd);
    if (clr) return 0;
    case (op)
      0: return (acc + opnd) % 256;
      1: return (acc - opnd + 256) % 256;
      2: return acc ^ opnd;
      default: return (acc * (1 << opnd)) % 256;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input bit clr, input logic [1:0] op, input logic [2:0] opnd,
                         output logic [7:0] d, output logic m, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_clear = clr; cmd_op = op; cmd_operand = opnd;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    d = rsp_data; m = rsp_mismatch;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit         clr;
    logic [1:0] op;
    logic [2:0] opnd;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, d0;
    logic       m, m0;
    int         lat, n, bad;
    bit         clr;
    logic [1:0] op;
    logic [2:0] opnd;

    vecs[0] = '{0, 2'b00, 3'd5, 8'h05, OP_LAT};
    vecs[1] = '{0, 2'b00, 3'd7, 8'h0C, OP_LAT};
    vecs[2] = '{0, 2'b10, 3'd6, 8'h0A, OP_LAT};
    vecs[3] = '{1, 2'b00, 3'd0, 8'h00, CL_LAT};
    vecs[4] = '{0, 2'b00, 3'd2, 8'h02, OP_LAT};
    vecs[5] = '{0, 2'b01, 3'd3, 8'hFF, OP_LAT};
    vecs[6] = '{1, 2'b11, 3'd5, 8'h00, CL_LAT};
    vecs[7] = '{0, 2'b00, 3'd3, 8'h03, OP_LAT};
    vecs[8] = '{0, 2'b11, 3'd7, 8'h80, OP_LAT};
    vecs[9] = '{0, 2'b11, 3'd0, 8'h80, OP_LAT};

    reset = 1'b0; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_op = '0; cmd_operand = '0;
    rsp_ready = 1'b0;

    // Reset state and INIT sequence
    repeat (3) @(posedge clock);
    #1;
    chk("rst_calc_in", int'(calc_in), 8'h02);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    clk_rises = 0; rst_rises = 0;
    reset = 1'b1;
    n = 0; bad = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clock); #1; n++;
      if (rsp_valid) bad++;
    end
    chk("init_ready_delay", n, 2 * HP);
    chk("init_clk_rises", clk_rises, 1);
    chk("init_rst_rises", rst_rises, 1);
    chk("init_no_rsp", bad, 0);

    // Table vectors
    ref_acc = 0;
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].clr, vecs[i].op, vecs[i].opnd, d, m, lat);
      ref_acc = ref_step(ref_acc, vecs[i].clr, int'(vecs[i].op), int'(vecs[i].opnd));
      chk($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_mism", i), int'(m), 0);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Backpressure with a pending command held on cmd_valid
    run_cmd(1'b1, 2'b00, 3'd0, d, m, lat);
    ref_acc = 0;
    cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_op = 2'b00; cmd_operand = 3'd4;
    @(posedge clock); #1;
    cmd_operand = 3'd6;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clock); #1; n++;
    end
    ref_acc = ref_step(ref_acc, 0, 0, 4);
    chk("bp_first_data", int'(rsp_data), ref_acc);
    d0 = rsp_data; m0 = rsp_mismatch; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (rsp_data != d0 || rsp_mismatch != m0 || calc_in[0] || cmd_ready || !rsp_valid) bad++;
    end
    chk("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", int'(cmd_ready), 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("bp_accepted", int'(cmd_ready), 0);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    ref_acc = ref_step(ref_acc, 0, 0, 6);
    chk("bp_second_lat", lat, OP_LAT);
    chk("bp_second_data", int'(rsp_data), ref_acc);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;

    // Faulty calculator output
    fault_zero = 1'b1;
    run_cmd(1'b1, 2'b00, 3'd0, d, m, lat);
    ref_acc = 0;
    chk("fault_clear_mism", int'(m), 0);
    run_cmd(1'b0, 2'b00, 3'd1, d, m, lat);
    ref_acc = ref_step(ref_acc, 0, 0, 1);
    chk("fault_add_data", int'(d), 0);
    chk("fault_add_mism", int'(m), 1);
    fault_zero = 1'b0;

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      clr  = ($urandom_range(7) == 0);
      op   = 2'($urandom_range(3));
      opnd = 3'($urandom_range(7));
      run_cmd(clr, op, opnd, d, m, lat);
      ref_acc = ref_step(ref_acc, clr, int'(op), int'(opnd));
      chk($sformatf("rnd%0d_data", i), int'(d), ref_acc);
      chk($sformatf("rnd%0d_mism", i), int'(m), 0);
      chk($sformatf("rnd%0d_lat", i), lat, clr ? CL_LAT : OP_LAT);
    end

    // Reset asserted mid-FIRE
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_op = 2'b00; cmd_operand = 3'd3;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (2 * HP + 1) @(posedge clock);
    #1;
    chk("midfire_en", int'(calc_in[2]), 1);
    reset = 1'b0;
    #1;
    chk("midfire_calc_in", int'(calc_in), 8'h02);
    chk("midfire_rsp_valid", int'(rsp_valid), 0);
    chk("midfire_rsp_data", int'(rsp_data), 0);
    chk("midfire_rsp_mism", int'(rsp_mismatch), 0);
    chk("midfire_cmd_ready", int'(cmd_ready), 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    n = 0; bad = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clock); #1; n++;
      if (rsp_valid) bad++;
    end
    chk("midfire_no_rsp", bad, 0);
    chk("midfire_ready_delay", n, 2 * HP);
    ref_acc = 0;
    run_cmd(1'b0, 2'b00, 3'd5, d, m, lat);
    ref_acc = ref_step(ref_acc, 0, 0, 5);
    chk("post_reset_data", int'(d), ref_acc);
    chk("post_reset_mism", int'(m), 0);
    chk("post_reset_lat", lat, OP_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
